// File: rtl/uart_pkg.sv
// Shared state encoding and register map for the UART peripheral.
// Build with UART_PARITY_EN defined to add an even-parity bit to both TX and RX frames.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_bit_state_t;

    localparam int   CTRL_SEND_BIT   = 0;
    localparam int   CTRL_NEWRX_BIT  = 1;
    localparam int   CTRL_PARERR_BIT = 2;
    localparam logic REG_CTRL        = 1'b0;
    localparam logic REG_DATA        = 1'b1;

`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
endpackage

// File: rtl/uart_periph_regs_if.sv
// Register bus between the UART control FSM (master) and the peripheral (slave).
interface uart_periph_regs_if;
    logic        wr_i;
    logic        reg_sel_i;
    logic [31:0] entrada_i;
    logic [31:0] salida_o;

    modport master (output wr_i, reg_sel_i, entrada_i, input salida_o);
    modport slave  (input wr_i, reg_sel_i, entrada_i, output salida_o);
endinterface

// File: rtl/uart_rx_deser.sv
// RX path: 2-flop synchronizer, mid-bit sampling FSM, optional parity check.
// o_byte_valid pulses on the stop-bit sample when the stop bit is 1.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CTR_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_par_err
);
    localparam logic [CTR_W-1:0] LAST = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CTR_W-1:0] HALF = CTR_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_s1, r_s2;
    uart_bit_state_t  r_st, w_st_nxt;
    logic [CTR_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_sh, w_sh_nxt;
    logic             r_par, w_par_nxt;
    logic             w_valid;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_rx;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st  <= IDLE;
            r_cnt <= '0;
            r_bit <= '0;
            r_sh  <= '0;
            r_par <= 1'b0;
        end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
            r_bit <= w_bit_nxt;
            r_sh  <= w_sh_nxt;
            r_par <= w_par_nxt;
        end
    end

    always_comb begin
        w_st_nxt  = r_st;
        w_cnt_nxt = r_cnt + 1'b1;
        w_bit_nxt = r_bit;
        w_sh_nxt  = r_sh;
        w_par_nxt = r_par;
        w_valid   = 1'b0;
        case (r_st)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!r_s2) w_st_nxt = START;
            end
            START: if (r_cnt == HALF) begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                w_st_nxt  = r_s2 ? IDLE : DATA;
            end
            DATA: if (r_cnt == LAST) begin
                w_cnt_nxt = '0;
                w_sh_nxt  = {r_s2, r_sh[7:1]};
                w_bit_nxt = r_bit + 1'b1;
                if (r_bit == 3'd7) w_st_nxt = PARITY_EN ? PARITY : STOP;
            end
            PARITY: if (r_cnt == LAST) begin
                w_cnt_nxt = '0;
                w_par_nxt = r_s2;
                w_st_nxt  = STOP;
            end
            STOP: if (r_cnt == LAST) begin
                w_cnt_nxt = '0;
                w_valid   = r_s2;
                w_st_nxt  = IDLE;
            end
            default: begin
                w_cnt_nxt = '0;
                w_st_nxt  = IDLE;
            end
        endcase
    end

    assign o_byte_valid = w_valid;
    assign o_byte       = r_sh;
    assign o_par_err    = PARITY_EN && ((^r_sh) != r_par);
endmodule

// File: rtl/uart_periph_regs.sv
// Register-mapped UART: ctrl/data registers, TX serializer, RX via uart_rx_deser.
// UART_PARITY_EN (see uart_pkg) enables even parity and the PAR_ERR flag.
module uart_periph_regs
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CTR_W        = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    uart_periph_regs_if.slave  bus,
    input  logic               rx_i,
    output logic               tx_o
);
    localparam logic [CTR_W-1:0] LAST = CTR_W'(CLKS_PER_BIT - 1);

    logic             r_send, r_new_rx, r_par_err;
    logic [7:0]       r_tx_data, r_rx_data;
    uart_bit_state_t  r_tx_st, w_tx_st_nxt;
    logic [CTR_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_bit, w_tx_bit_nxt;
    logic [7:0]       r_tx_sh, w_tx_sh_nxt;
    logic             r_tx_par, w_tx_par_nxt;
    logic             w_tx_o, w_tx_done, w_tx_end, w_tx_idle, w_start;
    logic             w_ctrl_wr, w_data_wr;
    logic             w_rx_valid, w_rx_par_err;
    logic [7:0]       w_rx_byte;
    logic [31:0]      w_ctrl;
    logic             w_unused;

    assign w_ctrl_wr = bus.wr_i && (bus.reg_sel_i == REG_CTRL);
    assign w_data_wr = bus.wr_i && (bus.reg_sel_i == REG_DATA);
    assign w_tx_end  = (r_tx_cnt == LAST);
    // The last STOP cycle counts as idle so a back-to-back SEND is not lost.
    assign w_tx_idle = (r_tx_st == IDLE) || ((r_tx_st == STOP) && w_tx_end);
    assign w_start   = w_ctrl_wr && bus.entrada_i[CTRL_SEND_BIT] && w_tx_idle;
    assign w_unused  = &{1'b0, bus.entrada_i[31:8]};

    uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT), .CTR_W(CTR_W)) u_rx (
        .i_clk        (clk_i),
        .i_rst_n      (reset_i),
        .i_rx         (rx_i),
        .o_byte_valid (w_rx_valid),
        .o_byte       (w_rx_byte),
        .o_par_err    (w_rx_par_err)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_tx_st  <= IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx_par <= 1'b0;
        end else begin
            r_tx_st  <= w_tx_st_nxt;
            r_tx_cnt <= w_tx_cnt_nxt;
            r_tx_bit <= w_tx_bit_nxt;
            r_tx_sh  <= w_tx_sh_nxt;
            r_tx_par <= w_tx_par_nxt;
        end
    end

    always_comb begin
        w_tx_st_nxt  = r_tx_st;
        w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        w_tx_bit_nxt = r_tx_bit;
        w_tx_sh_nxt  = r_tx_sh;
        w_tx_par_nxt = r_tx_par;
        w_tx_done    = 1'b0;
        w_tx_o       = 1'b1;
        case (r_tx_st)
            IDLE: w_tx_cnt_nxt = '0;
            START: begin
                w_tx_o = 1'b0;
                if (w_tx_end) begin
                    w_tx_st_nxt  = DATA;
                    w_tx_cnt_nxt = '0;
                    w_tx_bit_nxt = '0;
                end
            end
            DATA: begin
                w_tx_o = r_tx_sh[0];
                if (w_tx_end) begin
                    w_tx_cnt_nxt = '0;
                    w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
                    w_tx_bit_nxt = r_tx_bit + 1'b1;
                    if (r_tx_bit == 3'd7) w_tx_st_nxt = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_tx_o = r_tx_par;
                if (w_tx_end) begin
                    w_tx_st_nxt  = STOP;
                    w_tx_cnt_nxt = '0;
                end
            end
            STOP: if (w_tx_end) begin
                w_tx_done    = 1'b1;
                w_tx_st_nxt  = IDLE;
                w_tx_cnt_nxt = '0;
            end
            default: begin
                w_tx_st_nxt  = IDLE;
                w_tx_cnt_nxt = '0;
            end
        endcase
        // Snapshot the data register so later writes cannot corrupt this frame.
        if (w_start) begin
            w_tx_st_nxt  = START;
            w_tx_cnt_nxt = '0;
            w_tx_sh_nxt  = r_tx_data;
            w_tx_par_nxt = ^r_tx_data;
        end
    end

    assign tx_o = w_tx_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_send    <= 1'b0;
            r_new_rx  <= 1'b0;
            r_par_err <= 1'b0;
            r_tx_data <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_start)        r_send <= 1'b1;
            else if (w_tx_done) r_send <= 1'b0;

            // A store from RX beats a simultaneous software clear.
            if (w_rx_valid)     r_new_rx <= 1'b1;
            else if (w_ctrl_wr) r_new_rx <= bus.entrada_i[CTRL_NEWRX_BIT];

            if (w_rx_valid && w_rx_par_err)                    r_par_err <= 1'b1;
            else if (w_ctrl_wr && !bus.entrada_i[CTRL_PARERR_BIT]) r_par_err <= 1'b0;

            if (w_data_wr)  r_tx_data <= bus.entrada_i[7:0];
            if (w_rx_valid) r_rx_data <= w_rx_byte;
        end
    end

    always_comb begin
        w_ctrl                  = '0;
        w_ctrl[CTRL_SEND_BIT]   = r_send;
        w_ctrl[CTRL_NEWRX_BIT]  = r_new_rx;
        w_ctrl[CTRL_PARERR_BIT] = r_par_err;
    end

    assign bus.salida_o = (bus.reg_sel_i == REG_DATA) ? {24'b0, r_rx_data} : w_ctrl;
endmodule

// File: tb/tb_uart_periph_regs.sv
// Self-checking bench for uart_periph_regs at CLKS_PER_BIT=4: vector tables plus random frames vs. a frame-level model.
module tb_uart_periph_regs;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 11 : 10;
    // Store edge after first start-bit drive: 2 sync + 1 detect + half bit + remaining bit-times.
    localparam int RX_STORE = 3 + CPB / 2 + (NB - 1) * CPB;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    logic rx_i = 1'b1;
    logic tx_o;

    uart_periph_regs_if bus();

    uart_periph_regs #(.CLKS_PER_BIT(CPB), .CTR_W(16)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus),
        .rx_i    (rx_i),
        .tx_o    (tx_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model of software-visible state.
    logic       m_newrx  = 1'b0;
    logic       m_parerr = 1'b0;
    logic [7:0] m_rxdata = 8'h00;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        par_flip;
        bit          clr_at_store;
        bit          clr_after;
        logic [31:0] exp_ctrl;
        logic [31:0] exp_rdata;
    } rx_vec_t;

    typedef struct {
        logic [7:0] data;
        bit         inject;
        logic       exp_par;
    } tx_vec_t;

    rx_vec_t rxv[6];
    tx_vec_t txv[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_ctrl();
        return {29'b0, m_parerr, m_newrx, 1'b0};
    endfunction

    // Serial frame, bit-time order: start, D0..D7, [parity], stop.
    function automatic logic [10:0] frame(input logic [7:0] b, input logic pbit);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (PAR) f[9] = pbit;
        return f;
    endfunction

    task automatic bus_wr(input logic sel, input logic [31:0] d);
        @(posedge clk); #1;
        bus.wr_i = 1'b1; bus.reg_sel_i = sel; bus.entrada_i = d;
        @(posedge clk); #1;
        bus.wr_i = 1'b0; bus.reg_sel_i = REG_CTRL;
        if (sel == REG_CTRL) begin
            m_newrx = d[1];
            if (!d[2]) m_parerr = 1'b0;
        end
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit inject, input logic pbit);
        logic [10:0] f;
        int bad_wave, bad_send;
        f = frame(b, pbit);
        bad_wave = 0;
        bad_send = 0;
        bus_wr(REG_DATA, {24'b0, b});
        bus_wr(REG_CTRL, 32'h1);
        for (int i = 0; i < NB * CPB; i++) begin
            @(negedge clk);
            if (tx_o !== f[i / CPB]) bad_wave++;
            if (bus.reg_sel_i == REG_CTRL && bus.salida_o[0] !== 1'b1) bad_send++;
            if (inject) begin
                if (i == 5)      begin bus.wr_i = 1'b1; bus.reg_sel_i = REG_DATA; bus.entrada_i = 32'hFF; end
                else if (i == 6) begin bus.wr_i = 1'b1; bus.reg_sel_i = REG_CTRL; bus.entrada_i = 32'h1; end
                else if (i == 7) begin bus.wr_i = 1'b0; end
            end
        end
        @(negedge clk);
        check("tx_wave_errs", 32'(bad_wave), 32'd0);
        check("tx_send_hold_errs", 32'(bad_send), 32'd0);
        check("tx_send_clear", bus.salida_o, m_ctrl());
        check("tx_line_idle", 32'(tx_o), 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                            input bit clr_at_store);
        logic [10:0] f;
        logic prev_new;
        f = frame(b, (^b) ^ par_flip);
        f[NB - 1] = stop;
        prev_new = m_newrx;
        for (int i = 0; i < RX_STORE + 4; i++) begin
            @(posedge clk); #1;
            rx_i = (i < NB * CPB) ? f[i / CPB] : 1'b1;
            bus.wr_i = clr_at_store && (i == RX_STORE - 1);
            bus.reg_sel_i = REG_CTRL;
            bus.entrada_i = 32'h0;
            @(negedge clk);
            if (stop && i == RX_STORE - 1) check("rx_newrx_before_store", 32'(bus.salida_o[1]), 32'(prev_new));
            if (stop && i == RX_STORE)     check("rx_newrx_at_store", 32'(bus.salida_o[1]), 32'd1);
        end
        if (stop) begin
            m_rxdata = b;
            m_newrx  = 1'b1;
            if (PAR && par_flip) m_parerr = 1'b1;
        end
    endtask

    task automatic read_both(output logic [31:0] c, output logic [31:0] d);
        @(negedge clk);
        bus.reg_sel_i = REG_CTRL; #1; c = bus.salida_o;
        bus.reg_sel_i = REG_DATA; #1; d = bus.salida_o;
        bus.reg_sel_i = REG_CTRL;
    endtask

    initial begin
        logic [31:0] c, d;
        int bad;
        logic [7:0] rb;
        logic rs, rf;

        bus.wr_i = 1'b0; bus.reg_sel_i = REG_CTRL; bus.entrada_i = '0;

        rxv[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2, 32'h3C};
        rxv[1] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3C};
        rxv[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2, 32'h55};
        rxv[3] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2, 32'hAA};
        rxv[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 32'hC3};
        rxv[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, (PAR ? 32'h6 : 32'h2), 32'h07};
        txv[0] = '{8'hA5, 1'b0, 1'b0};
        txv[1] = '{8'h07, 1'b0, 1'b1};
        txv[2] = '{8'h00, 1'b0, 1'b0};
        txv[3] = '{8'h5A, 1'b1, 1'b0};

        #12;
        check("reset_tx_line", 32'(tx_o), 32'd1);
        read_both(c, d);
        check("reset_ctrl", c, 32'h0);
        check("reset_rdata", d, 32'h0);
        @(negedge clk) reset_i = 1'b1;

        foreach (txv[k]) tx_frame(txv[k].data, txv[k].inject, txv[k].exp_par);

        foreach (rxv[k]) begin
            rx_frame(rxv[k].data, rxv[k].stop, rxv[k].par_flip, rxv[k].clr_at_store);
            read_both(c, d);
            check("rxtab_ctrl", c, rxv[k].exp_ctrl);
            check("rxtab_rdata", d, rxv[k].exp_rdata);
            if (rxv[k].clr_after) begin
                bus_wr(REG_CTRL, 32'h0);
                read_both(c, d);
                check("rxtab_clear", c, 32'h0);
            end
        end

        // One-cycle low pulse must be rejected as a glitch.
        @(posedge clk); #1 rx_i = 1'b0;
        @(posedge clk); #1 rx_i = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        read_both(c, d);
        check("glitch_ctrl", c, m_ctrl());
        check("glitch_rdata", d, {24'b0, m_rxdata});

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            tx_frame(rb, bit'($urandom_range(0, 1)), ^rb);
        end
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rf = PAR && ($urandom_range(0, 1) == 1);
            rx_frame(rb, rs, rf, 1'b0);
            read_both(c, d);
            check("rand_rx_ctrl", c, m_ctrl());
            check("rand_rx_rdata", d, {24'b0, m_rxdata});
            if ($urandom_range(0, 1) == 1) bus_wr(REG_CTRL, 32'h0);
        end

        // Reset in the middle of a TX frame, with a nonzero byte held in rx_data.
        rx_frame(8'h99, 1'b1, 1'b0, 1'b0);
        bus_wr(REG_DATA, 32'hA5);
        bus_wr(REG_CTRL, 32'h1);
        repeat (10) @(posedge clk);
        #3 reset_i = 1'b0;
        #1 check("midrst_tx_line", 32'(tx_o), 32'd1);
        bus.reg_sel_i = REG_CTRL; #1 check("midrst_ctrl", bus.salida_o, 32'h0);
        bus.reg_sel_i = REG_DATA; #1 check("midrst_rdata", bus.salida_o, 32'h0);
        bus.reg_sel_i = REG_CTRL;
        m_newrx = 1'b0; m_parerr = 1'b0; m_rxdata = 8'h00;
        @(negedge clk) reset_i = 1'b1;
        bad = 0;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || bus.salida_o !== 32'h0) bad++;
        end
        check("postrst_idle_errs", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
